// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, queue entry type and buffer state encoding
// for the register-file write buffer.
package regfile_pkg;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } wbuf_state_t;
endpackage

// File: rtl/regfile_wbuf_fifo.sv
// regfile_wbuf_fifo: circular buffer of write-back entries with occupancy count.
// Storage and read pointer are exported so the owner can search pending entries.
module regfile_wbuf_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  wb_entry_t     wr_entry,
    output wb_entry_t     head,
    output wb_entry_t     entries [DEPTH],
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count
);
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= wr_entry;
    end

    assign head = entries[rd_ptr];
endmodule

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: in-order write-back queue driving the register file write port,
// with hold and flush-to-empty. Forwarding search is built only with REGFILE_WBUF_FWD_EN.
module regfile_write_buffer #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DEPTH  = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    output logic              rf_en,
    output logic [CW-1:0]     count,
    input  logic [ADDR_W-1:0] fwd_reg,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);
    import regfile_pkg::*;

    wbuf_state_t   state, state_nx;
    wb_entry_t     wr_entry, head;
    wb_entry_t     entries [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic          push, pop;

    assign wr_entry = '{idx: in_reg, data: in_data};
    // No pass-through when full: readiness ignores a same-cycle pop.
    assign in_ready = (count < CW'(DEPTH)) && (state != FLUSH);
    assign push     = in_valid && in_ready;
    assign pop      = (state != IDLE) && (count != '0) && (!hold || state == FLUSH);
    assign rf_en    = rf_reg_write;

    regfile_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .entries  (entries),
        .rd_ptr   (rd_ptr),
        .count    (count)
    );

    always_comb begin
        state_nx   = state;
        flush_done = 1'b0;
        case (state)
            IDLE:    state_nx = flush_req ? FLUSH : (push ? DRAIN : IDLE);
            DRAIN:   state_nx = flush_req ? FLUSH :
                                (pop && !push && count == CW'(1)) ? IDLE : DRAIN;
            FLUSH: begin
                // Last write was issued on the edge that emptied the queue.
                if (count == '0) begin
                    flush_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            rf_reg_write  <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            state        <= state_nx;
            rf_reg_write <= pop;
            if (pop) begin
                rf_write_reg  <= head.idx;
                rf_write_data <= head.data;
            end
        end
    end

`ifdef REGFILE_WBUF_FWD_EN
    // Oldest to youngest so later matches overwrite; the in-flight write ranks lowest.
    always_comb begin
        fwd_hit  = rf_reg_write && (rf_write_reg == fwd_reg);
        fwd_data = fwd_hit ? rf_write_data : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && entries[rd_ptr + PW'(i)].idx == fwd_reg) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[rd_ptr + PW'(i)].data;
            end
        end
    end
`else
    logic unused_fwd;
    always_comb begin
        unused_fwd = ^{fwd_reg, rd_ptr};
        for (int i = 0; i < DEPTH; i++) unused_fwd = unused_fwd ^ (^entries[i]);
    end
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif
endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb_regfile_write_buffer: directed and random checks of the write buffer against a
// queue-based model of the write-back rules and a harness register file.
module tb_regfile_write_buffer;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        in_valid, in_ready, hold, flush_req, flush_done;
    logic [4:0]  in_reg, rf_write_reg, fwd_reg;
    logic [63:0] in_data, rf_write_data, fwd_data;
    logic        rf_reg_write, rf_en, fwd_hit;
    logic [2:0]  count;

    regfile_write_buffer #(.DEPTH(DEPTH)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg        (in_reg),
        .in_data       (in_data),
        .hold          (hold),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .rf_en         (rf_en),
        .count         (count),
        .fwd_reg       (fwd_reg),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data)
    );

    always #5 Clk = ~Clk;

    // Harness register file fed by the DUT write port.
    logic [63:0] file_h [32] = '{default: 64'h0};
    always @(posedge Clk) if (rf_en) file_h[rf_write_reg] <= rf_write_data;

    typedef struct {
        logic [4:0]  r;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    logic [63:0] file_m [32] = '{default: 64'h0};
    bit          flushing, exp_wr;
    logic [4:0]  exp_reg;
    logic [63:0] exp_data;
    int          compared = 0, mismatched = 0, pulses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void fwd_model(output logic h, output logic [63:0] d);
        h = 1'b0;
        d = '0;
`ifdef REGFILE_WBUF_FWD_EN
        if (exp_wr && exp_reg == fwd_reg) begin
            h = 1'b1;
            d = exp_data;
        end
        foreach (q[i]) if (q[i].r == fwd_reg) begin
            h = 1'b1;
            d = q[i].d;
        end
`endif
    endfunction

    // One clock: check combinational outputs mid-cycle, advance model at the edge,
    // then check the registered write port just after the edge.
    task automatic tick();
        bit          rdy, fd, push, pop;
        logic        h;
        logic [63:0] fdat;
        ent_t        e;
        @(negedge Clk);
        rdy = (q.size() < DEPTH) && !flushing;
        fd  = flushing && q.size() == 0;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("count", 64'(count), 64'(q.size()));
        chk("flush_done", 64'(flush_done), 64'(fd));
        fwd_model(h, fdat);
        chk("fwd_hit", 64'(fwd_hit), 64'(h));
        chk("fwd_data", fwd_data, fdat);
        push = in_valid && rdy;
        pop  = q.size() > 0 && (!hold || flushing);
        @(posedge Clk);
        if (exp_wr) file_m[exp_reg] = exp_data;
        exp_wr = pop;
        if (pop) begin
            e        = q.pop_front();
            exp_reg  = e.r;
            exp_data = e.d;
        end
        if (push) q.push_back('{r: in_reg, d: in_data});
        if (fd) flushing = 1'b0;
        else if (flush_req && !flushing) flushing = 1'b1;
        #1;
        chk("rf_reg_write", 64'(rf_reg_write), 64'(exp_wr));
        chk("rf_en", 64'(rf_en), 64'(exp_wr));
        chk("rf_write_reg", 64'(rf_write_reg), 64'(exp_reg));
        chk("rf_write_data", rf_write_data, exp_data);
    endtask

    task automatic push_one(input logic [4:0] r, input logic [63:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b1; in_valid = 1'b0; hold = 1'b0; flush_req = 1'b0;
        in_reg = '0; in_data = '0; fwd_reg = '0;
        flushing = 1'b0; exp_wr = 1'b0; exp_reg = '0; exp_data = '0;
        #2 Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rf_reg_write", 64'(rf_reg_write), 64'd0);
        chk("rst_rf_en", 64'(rf_en), 64'd0);
        chk("rst_rf_write_reg", 64'(rf_write_reg), 64'd0);
        chk("rst_rf_write_data", rf_write_data, 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        Rst_n = 1'b1;

        // Single write: rf write one edge after accept, file updated the edge after.
        fwd_reg = 5'd5;
        push_one(5'd5, 64'hDEAD_BEEF);
        tick();
        tick();
        chk("file_r5", file_h[5], 64'hDEAD_BEEF);

        // Fill under hold, fifth request refused, then four back-to-back writes.
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push_one(5'(10 + i), 64'(100 + i));
        in_valid = 1'b1; in_reg = 5'd20; in_data = 64'h55;
        tick();
        tick();
        in_valid = 1'b0;
        hold = 1'b0;
        repeat (6) tick();

        // Same register twice: last write wins, forwarding sees the younger value.
        hold = 1'b1;
        fwd_reg = 5'd3;
        push_one(5'd3, 64'd1);
        push_one(5'd3, 64'd2);
        tick();
        hold = 1'b0;
        repeat (4) tick();
        chk("file_r3", file_h[3], 64'd2);

        // Flush with hold asserted and requests still offered.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push_one(5'(7 + i), 64'(700 + i));
        in_valid = 1'b1; in_reg = 5'd30; in_data = 64'h77;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (flush_done) pulses++;
        end
        chk("flush_pulses", 64'(pulses), 64'd1);
        in_valid = 1'b0;
        hold = 1'b0;
        repeat (4) tick();

        // Flush requested while idle and empty.
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (3) tick();

        // Reset with two entries queued discards them.
        hold = 1'b1;
        push_one(5'd12, 64'hAAAA);
        push_one(5'd13, 64'hBBBB);
        tick();
        Rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_rf_reg_write", 64'(rf_reg_write), 64'd0);
        q.delete();
        flushing = 1'b0; exp_wr = 1'b0; exp_reg = '0; exp_data = '0;
        hold = 1'b0;
        tick();
        Rst_n = 1'b1;
        repeat (4) tick();

        // Steady push and pop at two entries, wrapping the pointers.
        hold = 1'b1;
        push_one(5'd1, 64'h1001);
        push_one(5'd2, 64'h1002);
        hold = 1'b0;
        for (int i = 0; i < 10; i++) push_one(5'(i % 8), 64'(64'h2000 + i));
        repeat (4) tick();

        // Random traffic on a small register set to provoke forwarding hits.
        for (int k = 0; k < 400; k++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_reg    = 5'($urandom_range(0, 7));
            in_data   = {$urandom, $urandom};
            hold      = $urandom_range(0, 3) == 0;
            flush_req = $urandom_range(0, 19) == 0;
            fwd_reg   = 5'($urandom_range(0, 7));
            tick();
        end
        in_valid = 1'b0; hold = 1'b0; flush_req = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 32; i++) chk($sformatf("file_r%0d", i), file_h[i], file_m[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
